// File: rtl/fht_frame_sched.sv
// Three-bank frame scheduler: rotates buffer ownership between loader, FHT core and unloader
// so that input, transform and output of consecutive frames overlap.
module fht_frame_sched #(
  parameter int unsigned A_BIT     = 9,
  parameter int unsigned START_TMO = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  output logic             oIN_READY,
  output logic             oWE_LOAD,
  output logic [A_BIT-1:0] oWR_ADDR,
  output logic [1:0]       oWR_BANK,
  output logic             oCORE_START,
  output logic [1:0]       oCORE_BANK,
  input  logic             iCORE_RDY,
  input  logic             iOUT_READY,
  output logic             oRD_EN,
  output logic [A_BIT-1:0] oRD_ADDR,
  output logic [1:0]       oRD_BANK,
  output logic             oOUT_VALID,
  output logic             oOUT_LAST,
  output logic             oERR
);

  typedef enum logic [1:0] {BankEmpty, BankFull, BankDone} bank_st_e;
  typedef enum logic [1:0] {StIdle, StStart, StWaitAck, StBusy} core_st_e;

  localparam logic [A_BIT-1:0] AddrLast = '1;
  localparam int unsigned      TmoW     = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(START_TMO - 1);

  bank_st_e        bank_q [3];
  logic [1:0]      load_ptr, proc_ptr, unload_ptr;
  logic            run;
  core_st_e        core_st;
  logic [TmoW-1:0] tmo_cnt;
  logic            load_done, core_done, unload_done;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // run holds the loader off for the first cycle after reset release
  assign oIN_READY   = run & (bank_q[load_ptr] == BankEmpty);
  assign oWE_LOAD    = iIN_VALID & oIN_READY;
  assign oRD_EN      = (bank_q[unload_ptr] == BankDone) & iOUT_READY;
  assign oWR_BANK    = load_ptr;
  assign oRD_BANK    = unload_ptr;
  assign load_done   = oWE_LOAD & (oWR_ADDR == AddrLast);
  assign unload_done = oRD_EN & (oRD_ADDR == AddrLast);
  assign core_done   = (core_st == StBusy) & iCORE_RDY;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < 3; i++) bank_q[i] <= BankEmpty;
      load_ptr    <= 2'd0;
      proc_ptr    <= 2'd0;
      unload_ptr  <= 2'd0;
      run         <= 1'b0;
      oWR_ADDR    <= '0;
      oRD_ADDR    <= '0;
      core_st     <= StIdle;
      tmo_cnt     <= '0;
      oCORE_START <= 1'b0;
      oCORE_BANK  <= 2'd0;
      oOUT_VALID  <= 1'b0;
      oOUT_LAST   <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      run        <= 1'b1;
      oOUT_VALID <= oRD_EN;
      oOUT_LAST  <= unload_done;

      if (oWE_LOAD) oWR_ADDR <= oWR_ADDR + 1'b1;
      if (oRD_EN)   oRD_ADDR <= oRD_ADDR + 1'b1;

      // The three completions always target distinct banks, so they never collide.
      if (load_done) begin
        bank_q[load_ptr] <= BankFull;
        load_ptr         <= ptr_inc(load_ptr);
      end
      if (core_done) begin
        bank_q[proc_ptr] <= BankDone;
        proc_ptr         <= ptr_inc(proc_ptr);
      end
      if (unload_done) begin
        bank_q[unload_ptr] <= BankEmpty;
        unload_ptr         <= ptr_inc(unload_ptr);
      end

      oCORE_START <= 1'b0;
      unique case (core_st)
        StIdle: begin
          if ((bank_q[proc_ptr] == BankFull) && iCORE_RDY) begin
            core_st     <= StStart;
            oCORE_START <= 1'b1;
            oCORE_BANK  <= proc_ptr;
          end
        end
        StStart: begin
          core_st <= StWaitAck;
          tmo_cnt <= '0;
        end
        StWaitAck: begin
          if (!iCORE_RDY) begin
            core_st <= StBusy;
          end else if (tmo_cnt == TmoLast) begin
            // Bank stays FULL, so IDLE retries the same frame.
            core_st <= StIdle;
            oERR    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StBusy: begin
          if (iCORE_RDY) core_st <= StIdle;
        end
        default: core_st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Randomised scoreboard bench for fht_frame_sched: frame-level reference model, bench-side
// core model, and directed checks for reset, start latency, simultaneous events and timeout.
module tb_fht_frame_sched;

  localparam int A_BIT = 9;
  localparam int N     = 1 << A_BIT;

  typedef struct packed {
    logic [1:0]       bank;
    logic [A_BIT-1:0] addr;
    logic             last;
  } rd_exp_t;

  logic             iCLK = 1'b0;
  logic             iRESET;
  logic             iIN_VALID;
  logic             oIN_READY;
  logic             oWE_LOAD;
  logic [A_BIT-1:0] oWR_ADDR;
  logic [1:0]       oWR_BANK;
  logic             oCORE_START;
  logic [1:0]       oCORE_BANK;
  logic             iCORE_RDY;
  logic             iOUT_READY;
  logic             oRD_EN;
  logic [A_BIT-1:0] oRD_ADDR;
  logic [1:0]       oRD_BANK;
  logic             oOUT_VALID;
  logic             oOUT_LAST;
  logic             oERR;

  fht_frame_sched #(.A_BIT(A_BIT), .START_TMO(4)) dut (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .iIN_VALID   (iIN_VALID),
    .oIN_READY   (oIN_READY),
    .oWE_LOAD    (oWE_LOAD),
    .oWR_ADDR    (oWR_ADDR),
    .oWR_BANK    (oWR_BANK),
    .oCORE_START (oCORE_START),
    .oCORE_BANK  (oCORE_BANK),
    .iCORE_RDY   (iCORE_RDY),
    .iOUT_READY  (iOUT_READY),
    .oRD_EN      (oRD_EN),
    .oRD_ADDR    (oRD_ADDR),
    .oRD_BANK    (oRD_BANK),
    .oOUT_VALID  (oOUT_VALID),
    .oOUT_LAST   (oOUT_LAST),
    .oERR        (oERR)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // Stimulus controls set by the main sequence.
  int in_target = 0;
  bit in_rand   = 0;
  int out_mode  = 0;  // 0: always ready, 1: toggle, 2: random
  int dmin = 50, dmax = 50;
  bit ack_en    = 1;
  bit hold_mode = 0;

  // Frame-level reference model.
  int      ld_frames, ld_words, ul_frames, done_frames;
  bit      run_m;
  rd_exp_t exp_rd [$];
  logic [1:0] exp_start [$];
  int      prev_rden, prev_last, prev_start;
  int      start_cnt, last_start_cyc, last_load_cyc, sim_cyc;

  // Core model state.
  bit ack_pending;
  bit core_done_now;
  int busy_left;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    ld_frames = 0; ld_words = 0; ul_frames = 0; done_frames = 0;
    exp_rd.delete();
    exp_start.delete();
    prev_rden = 0; prev_last = 0; prev_start = 0;
    start_cnt = 0; last_start_cyc = -100; last_load_cyc = -100; sim_cyc = -1;
    ack_pending = 0;
    run_m = 0;
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  initial begin
    iIN_VALID = 1'b0;
    iOUT_READY = 1'b0;
    iCORE_RDY = 1'b1;
    busy_left = 0;
    core_done_now = 0;
    forever begin
      @(posedge iCLK);
      #1;
      cyc++;
      core_done_now = 0;
      iIN_VALID = (ld_frames < in_target) && (!in_rand || ($urandom_range(3, 0) != 0));
      case (out_mode)
        0:       iOUT_READY = 1'b1;
        1:       iOUT_READY = !iOUT_READY;
        default: iOUT_READY = ($urandom_range(2, 0) != 0);
      endcase
      if (iRESET) begin
        iCORE_RDY = 1'b1;
        busy_left = 0;
      end else if (ack_pending) begin
        ack_pending = 0;
        iCORE_RDY = 1'b0;
        busy_left = $urandom_range(dmax, dmin);
      end else if (!iCORE_RDY) begin
        if (hold_mode) begin
          // Finish exactly on the cycle the second frame's last sample is accepted.
          if (ld_frames == 1 && ld_words == N - 1 && iIN_VALID) begin
            iCORE_RDY = 1'b1;
            core_done_now = 1;
            sim_cyc = cyc;
            hold_mode = 0;
          end
        end else if (busy_left <= 1) begin
          iCORE_RDY = 1'b1;
          core_done_now = 1;
        end else begin
          busy_left--;
        end
      end
    end
  end

  // Monitor / scoreboard on the falling edge.
  initial begin
    int      exp_rdy, exp_rden;
    rd_exp_t e;
    model_clear();
    forever begin
      @(negedge iCLK);
      if (iRESET) begin
        model_clear();
      end else begin
        exp_rdy = int'(run_m && (ld_frames - ul_frames < 3));
        chk("in_ready", int'(oIN_READY), exp_rdy);
        chk("we_load", int'(oWE_LOAD), int'(iIN_VALID) & exp_rdy);
        if (iIN_VALID && exp_rdy != 0) begin
          chk("wr_bank", int'(oWR_BANK), ld_frames % 3);
          chk("wr_addr", int'(oWR_ADDR), ld_words);
          ld_words++;
          if (ld_words == N) begin
            for (int a = 0; a < N; a++) begin
              e.bank = 2'(ld_frames % 3);
              e.addr = A_BIT'(a);
              e.last = (a == N - 1);
              exp_rd.push_back(e);
            end
            exp_start.push_back(2'(ld_frames % 3));
            ld_frames++;
            ld_words = 0;
            last_load_cyc = cyc;
          end
        end

        exp_rden = int'((ul_frames < done_frames) && iOUT_READY);
        chk("rd_en", int'(oRD_EN), exp_rden);
        chk("out_valid", int'(oOUT_VALID), prev_rden);
        if (prev_rden != 0) chk("out_last", int'(oOUT_LAST), prev_last);
        prev_rden = exp_rden;
        prev_last = 0;
        if (exp_rden != 0) begin
          chk("rd_pending", int'(exp_rd.size() > 0), 1);
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            chk("rd_bank", int'(oRD_BANK), int'(e.bank));
            chk("rd_addr", int'(oRD_ADDR), int'(e.addr));
            prev_last = int'(e.last);
            if (e.last) ul_frames++;
          end
        end

        if (oCORE_START) begin
          start_cnt++;
          last_start_cyc = cyc;
          chk("start_pulse", prev_start, 0);
          chk("start_pending", int'(exp_start.size() > 0), 1);
          if (exp_start.size() > 0) begin
            chk("core_bank", int'(oCORE_BANK), int'(exp_start[0]));
            if (ack_en) begin
              void'(exp_start.pop_front());
              ack_pending = 1;
            end
          end
        end
        prev_start = int'(oCORE_START);
        if (core_done_now) done_frames++;
        run_m = 1;
      end
    end
  end

  task automatic apply_reset();
    in_target = 0;
    hold_mode = 0;
    ack_en = 1;
    @(posedge iCLK);
    #1 iRESET = 1'b1;
    repeat (3) @(posedge iCLK);
    #1 iRESET = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int frames, input int budget);
    int n = 0;
    while (ul_frames < frames && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    chk(name, int'(ul_frames >= frames), 1);
    repeat (3) @(negedge iCLK);
    chk({name, "_left"}, int'(exp_rd.size()), 0);
  endtask

  task automatic wait_starts(input string name, input int cnt, input int budget);
    int n = 0;
    while (start_cnt < cnt && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    chk(name, int'(start_cnt >= cnt), 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge iCLK);
  endtask

  initial begin
    int s;
    iRESET = 1'b1;
    // Reset values.
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_outs", int'({oIN_READY, oWE_LOAD, oWR_ADDR, oWR_BANK, oCORE_START, oCORE_BANK,
                          oRD_EN, oRD_ADDR, oRD_BANK, oOUT_VALID, oOUT_LAST, oERR}), 0);
    @(posedge iCLK);
    #1 iRESET = 1'b0;
    @(negedge iCLK);
    chk("rdy_release_cycle", int'(oIN_READY), 0);
    @(negedge iCLK);
    chk("rdy_after_release", int'(oIN_READY), 1);

    // Single frame, core busy 100 cycles.
    dmin = 100; dmax = 100; in_target = 1;
    wait_drain("single_drain", 1, 3000);
    chk("single_starts", start_cnt, 1);
    chk("start_latency", last_start_cyc - last_load_cyc, 2);
    chk("single_err", int'(oERR), 0);

    // Back-to-back frames with a slow core.
    apply_reset();
    dmin = 2000; dmax = 2000; in_target = 4;
    wait_drain("b2b_drain", 4, 15000);
    chk("b2b_starts", start_cnt, 4);

    // Reset mid-operation, then a fresh frame must land in bank 0.
    apply_reset();
    dmin = 300; dmax = 300; in_target = 2;
    repeat (800) @(negedge iCLK);
    apply_reset();
    dmin = 40; dmax = 40; in_target = 1;
    wait_drain("midrst_drain", 1, 3000);

    // Output backpressure: ready toggles every cycle.
    apply_reset();
    out_mode = 1; dmin = 50; dmax = 50; in_target = 2;
    wait_drain("bp_drain", 2, 6000);

    // Randomised traffic.
    apply_reset();
    out_mode = 2; in_rand = 1; dmin = 20; dmax = 600; in_target = 6;
    wait_drain("rand_drain", 6, 20000);
    chk("rand_err", int'(oERR), 0);

    // Load-complete of bank 1 in the same cycle the core finishes bank 0.
    apply_reset();
    out_mode = 0; in_rand = 0; dmin = 30; dmax = 30;
    hold_mode = 1;
    in_target = 2;
    wait_starts("sim_second_start", 2, 3000);
    chk("sim_load_cycle", last_load_cyc, sim_cyc);
    chk("sim_start_cycle", last_start_cyc, sim_cyc + 2);
    chk("sim_core_bank", int'(oCORE_BANK), 1);
    wait_drain("sim_drain", 2, 4000);

    // Start timeout: core ignores the start pulse.
    apply_reset();
    ack_en = 0; dmin = 40; dmax = 40; in_target = 1;
    wait_starts("tmo_first_start", 1, 2000);
    s = last_start_cyc;
    wait_cyc(s + 4);
    chk("tmo_err_before", int'(oERR), 0);
    wait_cyc(s + 5);
    chk("tmo_err_set", int'(oERR), 1);
    wait_starts("tmo_retry_start", 2, 50);
    chk("tmo_retry_cycle", last_start_cyc, s + 6);
    chk("tmo_retry_bank", int'(oCORE_BANK), 0);
    ack_en = 1;
    wait_drain("tmo_drain", 1, 3000);
    chk("tmo_err_sticky", int'(oERR), 1);
    apply_reset();
    @(negedge iCLK);
    chk("tmo_err_cleared", int'(oERR), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
